drive_mode_controller: RTL and testbench
========================================

Name: drive_mode_controller

Overview:
Parametrised successor to the robot's top-level mode FSM. It arbitrates IDLE / CAM (search-and-rescue) / IR (manual return-home) modes from decoded remote keys, and runs the CAM SEARCH/FOLLOW/PAUSE sub-FSM with lost-target hysteresis and a timed search sweep. It latches IR drive commands with an expiry timeout and emits a registered drive state plus a tx_reset pulse to the JSON/UART transmit path.

Parameters:
IR_HOLD_CYCLES, 25_000_000, cycles a latched IR drive command stays active after its last valid key (0.5 s at 50 MHz); must be >= 1
LOST_CYCLES, 5_000_000, consecutive cycles without orange_detected before FOLLOW falls back to SEARCH; must be >= 1
SWEEP_CYCLES, 50_000_000, cycles per LEFT/RIGHT half-sweep in SEARCH when no direction is given; must be >= 1
KEY_CAM, 8'h0F, key code selecting CAM mode
KEY_IR, 8'h13, key code selecting IR mode
KEY_IDLE, 8'h10, key code selecting IDLE mode

Ports:
clk_50  in  1  system clock
reset  in  1  synchronous, active-high reset
IR_button  in  8  decoded remote key code
IR_valid  in  1  one-cycle strobe, IR_button valid this cycle
CAM_direction  in  3  camera target direction: 001 left, 010 right, 011 ahead, other values none
speed  in  2  00 slow, 01 medium, 10 fast, 11 emergency stop
orange_detected  in  1  camera sees orange target
tx_reset  out  1  one-cycle pulse after a mode or CAM sub-state change
state  out  2  IDLE 00, CAM 01, IR 10
CAM_state  out  2  SEARCH 00, FOLLOW 01, PAUSE 11
drive_state  out  4  STOP 0, LEFT 1, RIGHT 2, SLOW 3, MEDIUM 4, FAST 5, REVERSE 6, LREVERSE 7, RREVERSE 8, HARD_L 9, HARD_R 10

Behaviour:
- All outputs are registered. A registered input affects state, CAM_state and drive_state at the next clk_50 edge (1-cycle latency).
- Reset (sync, dominant over every other input, also mid-operation): state=IDLE, CAM_state=PAUSE, drive_state=STOP, tx_reset=1 while reset is held. All counters and the sweep direction clear; the IR command latch is set to STOP.
- Mode changes occur only when IR_valid=1. KEY_CAM goes to CAM, KEY_IR goes to IR, KEY_IDLE goes to IDLE from any mode. A key equal to the current mode produces no change. When IR_valid=0, IR_button is ignored.
- CAM sub-FSM:
  - Any next mode other than CAM forces PAUSE.
  - PAUSE goes to SEARCH when the next mode is CAM. Entering SEARCH clears the sweep counter and sets sweep direction to LEFT.
  - SEARCH goes to FOLLOW when orange_detected=1.
  - In FOLLOW, the lost counter increments each cycle with orange_detected=0 and clears on any cycle with orange_detected=1. FOLLOW goes to SEARCH in the cycle the counter reaches LOST_CYCLES-1. With LOST_CYCLES=1, FOLLOW exits on the first miss.
- Drive priority in CAM and IR modes: speed=11 forces STOP above everything else. In IDLE, drive_state is always STOP.
- CAM/SEARCH drive:
  - Direction 010 gives RIGHT, 001 gives LEFT, 011 gives SLOW.
  - Any other direction gives the sweep: LEFT or RIGHT per sweep direction. The sweep direction toggles each time the sweep counter wraps at SWEEP_CYCLES-1.
- CAM/FOLLOW drive:
  - Direction 010 gives RIGHT, 001 gives LEFT.
  - Direction 011 with speed 00/01/10 gives SLOW/MEDIUM/FAST.
  - Any other direction holds the previous drive_state.
- IR mode, command latch:
  - IR_valid with a drive key loads the latch and reloads the hold counter to IR_HOLD_CYCLES-1.
  - Drive key map: 0C STOP, 07 LEFT, 09 RIGHT, 02 FAST, 05 MEDIUM, 08 SLOW, 00 REVERSE, 11 LREVERSE, 17 RREVERSE.
  - Unknown keys are ignored and do not reload the counter.
  - A mode key loads STOP into the latch.
  - The counter decrements each cycle. When it reaches 0 the latch becomes STOP.
- IR mode, obstacle override: when orange_detected=1, direction 010 gives HARD_L, 001 gives HARD_R, 011 gives REVERSE. Otherwise drive_state is the latch value. The override does not modify the latch or the counter.
- tx_reset is 1 for exactly one cycle after any edge where state or CAM_state changed. Back-to-back changes give consecutive pulses.
- Same-cycle events:
  - A mode key and orange_detected arrive together: the mode change wins, and the CAM sub-FSM evaluates against the next mode.
  - IR_valid and counter expiry coincide: the reload wins.

Test Plan:
- Reset held 3 cycles then released, no keys -> state=00, CAM_state=11, drive_state=0; tx_reset=1 during reset and 0 one cycle after release.
- IR_valid with KEY_CAM, then CAM_direction=000, SWEEP_CYCLES=4 -> CAM_state=00; drive LEFT for 4 cycles, RIGHT for 4 cycles, repeating; tx_reset pulses once.
- In FOLLOW with orange detected, CAM_direction=011 and speed=01, then orange drops for 2 cycles and returns, with LOST_CYCLES=3 -> stays FOLLOW with drive MEDIUM. Orange then absent 3 cycles -> SEARCH.
- IR mode, key 08 with IR_HOLD_CYCLES=5 -> drive SLOW for 5 cycles, then STOP. Key 07 re-sent at cycle 3 -> LEFT, held a further 5 cycles.
- IR mode with latch FAST, orange_detected=1 and direction 001 -> HARD_R. Orange cleared before expiry -> FAST resumes.
- speed=11 in CAM/FOLLOW and in IR mode with a latched command -> STOP. A mode key asserted mid-hold together with a reset pulse -> reset wins and all outputs return to reset values.

Source files
------------

// File: rtl/drive_mode_controller.sv
// drive_mode_controller: IDLE/CAM/IR mode arbiter with CAM search/follow sub-FSM,
// timed IR command latch and registered drive state plus tx_reset pulse.
module drive_mode_controller #(
    parameter int unsigned IR_HOLD_CYCLES = 25_000_000,
    parameter int unsigned LOST_CYCLES    = 5_000_000,
    parameter int unsigned SWEEP_CYCLES   = 50_000_000,
    parameter logic [7:0]  KEY_CAM        = 8'h0F,
    parameter logic [7:0]  KEY_IR         = 8'h13,
    parameter logic [7:0]  KEY_IDLE       = 8'h10
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic [7:0] IR_button,
    input  logic       IR_valid,
    input  logic [2:0] CAM_direction,
    input  logic [1:0] speed,
    input  logic       orange_detected,
    output logic       tx_reset,
    output logic [1:0] state,
    output logic [1:0] CAM_state,
    output logic [3:0] drive_state
);
    localparam int HW = $clog2(IR_HOLD_CYCLES + 1);
    localparam int LW = $clog2(LOST_CYCLES + 1);
    localparam int SW = $clog2(SWEEP_CYCLES + 1);

    typedef enum logic [1:0] {M_IDLE = 2'b00, M_CAM = 2'b01, M_IR = 2'b10} mode_t;
    typedef enum logic [1:0] {C_SEARCH = 2'b00, C_FOLLOW = 2'b01, C_PAUSE = 2'b11} cam_t;
    typedef enum logic [3:0] {
        D_STOP, D_LEFT, D_RIGHT, D_SLOW, D_MEDIUM, D_FAST,
        D_REVERSE, D_LREVERSE, D_RREVERSE, D_HARD_L, D_HARD_R
    } drive_t;

    mode_t           r_state, w_mode_nxt;
    cam_t            r_cam, w_cam_nxt;
    drive_t          r_drive, w_drive_nxt, r_latch, w_key_drive, w_cam_drv, w_ir_drv;
    logic            r_tx, r_sweep_dir;
    logic [HW-1:0]   r_hold;
    logic [LW-1:0]   r_lost;
    logic [SW-1:0]   r_sweep_cnt;
    logic            w_mode_key, w_key_known, w_lost_hit, w_sweep_wrap;

    assign w_mode_key   = IR_button == KEY_CAM || IR_button == KEY_IR || IR_button == KEY_IDLE;
    assign w_lost_hit   = r_cam == C_FOLLOW && !orange_detected && r_lost == LW'(LOST_CYCLES - 1);
    assign w_sweep_wrap = r_sweep_cnt == SW'(SWEEP_CYCLES - 1);

    always_comb begin
        w_mode_nxt = r_state;
        if (IR_valid)
            w_mode_nxt = IR_button == KEY_CAM  ? M_CAM :
                         IR_button == KEY_IR   ? M_IR  :
                         IR_button == KEY_IDLE ? M_IDLE : r_state;
        w_cam_nxt = w_mode_nxt != M_CAM ? C_PAUSE  :
                    r_cam == C_PAUSE    ? C_SEARCH :
                    r_cam == C_SEARCH   ? (orange_detected ? C_FOLLOW : C_SEARCH) :
                    w_lost_hit          ? C_SEARCH : C_FOLLOW;
    end

    always_comb begin
        w_key_known = 1'b1;
        w_key_drive = D_STOP;
        case (IR_button)
            8'h0C:   w_key_drive = D_STOP;
            8'h07:   w_key_drive = D_LEFT;
            8'h09:   w_key_drive = D_RIGHT;
            8'h02:   w_key_drive = D_FAST;
            8'h05:   w_key_drive = D_MEDIUM;
            8'h08:   w_key_drive = D_SLOW;
            8'h00:   w_key_drive = D_REVERSE;
            8'h11:   w_key_drive = D_LREVERSE;
            8'h17:   w_key_drive = D_RREVERSE;
            default: w_key_known = 1'b0;
        endcase
    end

    // FOLLOW with no usable direction keeps whatever it was last driving
    always_comb begin
        w_cam_drv = D_STOP;
        if (r_cam == C_SEARCH)
            w_cam_drv = CAM_direction == 3'b010 ? D_RIGHT :
                        CAM_direction == 3'b001 ? D_LEFT  :
                        CAM_direction == 3'b011 ? D_SLOW  :
                        r_sweep_dir             ? D_RIGHT : D_LEFT;
        else if (r_cam == C_FOLLOW)
            w_cam_drv = CAM_direction == 3'b010 ? D_RIGHT :
                        CAM_direction == 3'b001 ? D_LEFT  :
                        CAM_direction != 3'b011 ? r_drive :
                        speed == 2'b00          ? D_SLOW  :
                        speed == 2'b01          ? D_MEDIUM : D_FAST;
        w_ir_drv = !orange_detected         ? r_latch  :
                   CAM_direction == 3'b010  ? D_HARD_L :
                   CAM_direction == 3'b001  ? D_HARD_R :
                   CAM_direction == 3'b011  ? D_REVERSE : r_latch;
        w_drive_nxt = (r_state == M_IDLE || speed == 2'b11) ? D_STOP :
                      r_state == M_CAM ? w_cam_drv : w_ir_drv;
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_state     <= M_IDLE;
            r_cam       <= C_PAUSE;
            r_drive     <= D_STOP;
            r_tx        <= 1'b1;
            r_latch     <= D_STOP;
            r_hold      <= '0;
            r_lost      <= '0;
            r_sweep_cnt <= '0;
            r_sweep_dir <= 1'b0;
        end else begin
            r_state <= w_mode_nxt;
            r_cam   <= w_cam_nxt;
            r_drive <= w_drive_nxt;
            r_tx    <= w_mode_nxt != r_state || w_cam_nxt != r_cam;
            r_lost  <= (r_cam == C_FOLLOW && !orange_detected && !w_lost_hit) ? r_lost + 1'b1 : '0;
            if (w_cam_nxt == C_SEARCH && r_cam != C_SEARCH) begin
                r_sweep_cnt <= '0;
                r_sweep_dir <= 1'b0;
            end else if (r_cam == C_SEARCH) begin
                r_sweep_cnt <= w_sweep_wrap ? '0 : r_sweep_cnt + 1'b1;
                r_sweep_dir <= r_sweep_dir ^ w_sweep_wrap;
            end
            // a reload on the expiry cycle takes precedence over dropping to STOP
            if (IR_valid && w_mode_key) begin
                r_latch <= D_STOP;
            end else if (IR_valid && w_key_known && r_state == M_IR) begin
                r_latch <= w_key_drive;
                r_hold  <= HW'(IR_HOLD_CYCLES - 1);
            end else if (r_hold != '0) begin
                r_hold <= r_hold - 1'b1;
            end else begin
                r_latch <= D_STOP;
            end
        end
    end

    assign tx_reset    = r_tx;
    assign state       = r_state;
    assign CAM_state   = r_cam;
    assign drive_state = r_drive;
endmodule

// File: tb/tb_drive_mode_controller.sv
// tb_drive_mode_controller: table-driven vectors checked through an expected-result queue.
module tb_drive_mode_controller;
    logic       clk_50 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] IR_button = '0;
    logic       IR_valid = 1'b0;
    logic [2:0] CAM_direction = '0;
    logic [1:0] speed = '0;
    logic       orange_detected = 1'b0;
    logic       tx_reset;
    logic [1:0] state, CAM_state;
    logic [3:0] drive_state;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] key;
        logic [2:0] dir;
        logic [1:0] spd;
        logic       orn;
        logic [1:0] st;
        logic [1:0] cam;
        logic [3:0] drv;
        logic       tx;
    } vec_t;

    typedef struct {
        int         idx;
        logic [1:0] st;
        logic [1:0] cam;
        logic [3:0] drv;
        logic       tx;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   step = 0;

    drive_mode_controller #(
        .IR_HOLD_CYCLES(5),
        .LOST_CYCLES(3),
        .SWEEP_CYCLES(4)
    ) dut (
        .clk_50(clk_50),
        .reset(reset),
        .IR_button(IR_button),
        .IR_valid(IR_valid),
        .CAM_direction(CAM_direction),
        .speed(speed),
        .orange_detected(orange_detected),
        .tx_reset(tx_reset),
        .state(state),
        .CAM_state(CAM_state),
        .drive_state(drive_state)
    );

    always #5 clk_50 = ~clk_50;

    function automatic vec_t mk(input int rst, input int v, input int key, input int dir,
                                input int spd, input int orn, input int st, input int cam,
                                input int drv, input int tx);
        vec_t t;
        t.rst = rst[0]; t.v = v[0]; t.key = key[7:0]; t.dir = dir[2:0];
        t.spd = spd[1:0]; t.orn = orn[0]; t.st = st[1:0]; t.cam = cam[1:0];
        t.drv = drv[3:0]; t.tx = tx[0];
        return t;
    endfunction

    task automatic add(input int rst, input int v, input int key, input int dir, input int spd,
                       input int orn, input int st, input int cam, input int drv, input int tx);
        tbl.push_back(mk(rst, v, key, dir, spd, orn, st, cam, drv, tx));
    endtask

    task automatic chk(input string name, input int idx, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, req);
        end
    endtask

    task automatic apply(input vec_t t);
        exp_t e;
        reset = t.rst; IR_valid = t.v; IR_button = t.key;
        CAM_direction = t.dir; speed = t.spd; orange_detected = t.orn;
        sb.push_back('{idx: step, st: t.st, cam: t.cam, drv: t.drv, tx: t.tx});
        step++;
        @(posedge clk_50);
        #1;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard step %0d: got empty queue, expected one entry", step);
        end else begin
            e = sb.pop_front();
            chk("state", e.idx, int'(state), int'(e.st));
            chk("CAM_state", e.idx, int'(CAM_state), int'(e.cam));
            chk("drive_state", e.idx, int'(drive_state), int'(e.drv));
            chk("tx_reset", e.idx, int'(tx_reset), int'(e.tx));
        end
    endtask

    initial begin
        // reset and ignored keys in IDLE
        for (int i = 0; i < 3; i++) add(1, 0, 'h00, 0, 0, 0, 0, 3, 0, 1);
        add(0, 0, 'h00, 0, 0, 0, 0, 3, 0, 0);
        add(0, 1, 'h08, 0, 0, 0, 0, 3, 0, 0);
        add(0, 0, 'h0F, 0, 0, 0, 0, 3, 0, 0);
        // CAM search sweep: 4 LEFT, 4 RIGHT, then direction overrides
        add(0, 1, 'h0F, 0, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) add(0, 0, 'h00, 0, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 'h00, 0, 0, 0, 1, 0, 2, 0);
        add(0, 0, 'h00, 0, 0, 0, 1, 0, 1, 0);
        add(0, 0, 'h00, 2, 0, 0, 1, 0, 2, 0);
        add(0, 0, 'h00, 1, 0, 0, 1, 0, 1, 0);
        add(0, 0, 'h00, 3, 0, 0, 1, 0, 3, 0);
        add(0, 0, 'h00, 3, 3, 0, 1, 0, 0, 0);
        // FOLLOW with lost-target hysteresis
        add(0, 0, 'h00, 3, 1, 1, 1, 1, 3, 1);
        add(0, 0, 'h00, 3, 1, 1, 1, 1, 4, 0);
        add(0, 0, 'h00, 3, 1, 0, 1, 1, 4, 0);
        add(0, 0, 'h00, 3, 1, 0, 1, 1, 4, 0);
        add(0, 0, 'h00, 3, 1, 1, 1, 1, 4, 0);
        add(0, 0, 'h00, 3, 1, 0, 1, 1, 4, 0);
        add(0, 0, 'h00, 3, 1, 0, 1, 1, 4, 0);
        add(0, 0, 'h00, 3, 1, 0, 1, 0, 4, 1);
        add(0, 0, 'h00, 0, 1, 0, 1, 0, 1, 0);
        add(0, 0, 'h00, 0, 0, 1, 1, 1, 1, 1);
        add(0, 0, 'h00, 0, 0, 1, 1, 1, 1, 0);
        add(0, 0, 'h00, 2, 0, 1, 1, 1, 2, 0);
        add(0, 0, 'h00, 5, 0, 1, 1, 1, 2, 0);
        add(0, 0, 'h00, 3, 2, 1, 1, 1, 5, 0);
        add(0, 0, 'h00, 3, 0, 1, 1, 1, 3, 0);
        add(0, 0, 'h00, 3, 3, 1, 1, 1, 0, 0);
        add(0, 0, 'h00, 7, 0, 1, 1, 1, 0, 0);
        add(0, 0, 'h00, 1, 3, 1, 1, 1, 0, 0);
        // mode key together with orange: mode change wins
        add(0, 1, 'h13, 1, 0, 1, 2, 3, 1, 1);
        // IR latch: SLOW for 5 cycles, then STOP
        add(0, 1, 'h08, 0, 0, 0, 2, 3, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 'h00, 0, 0, 0, 2, 3, 3, 0);
        add(0, 0, 'h00, 0, 0, 0, 2, 3, 0, 0);
        // LEFT re-sent at cycle 3 extends the hold
        add(0, 1, 'h07, 0, 0, 0, 2, 3, 0, 0);
        add(0, 0, 'h00, 0, 0, 0, 2, 3, 1, 0);
        add(0, 0, 'h00, 0, 0, 0, 2, 3, 1, 0);
        add(0, 1, 'h07, 0, 0, 0, 2, 3, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 'h00, 0, 0, 0, 2, 3, 1, 0);
        add(0, 0, 'h00, 0, 0, 0, 2, 3, 0, 0);
        // FAST, unknown key does not reload, obstacle override, expiry
        add(0, 1, 'h02, 0, 0, 0, 2, 3, 0, 0);
        add(0, 1, 'h55, 0, 0, 0, 2, 3, 5, 0);
        add(0, 0, 'h00, 0, 0, 0, 2, 3, 5, 0);
        add(0, 0, 'h00, 1, 0, 1, 2, 3, 10, 0);
        add(0, 0, 'h00, 2, 0, 1, 2, 3, 9, 0);
        add(0, 0, 'h00, 0, 0, 0, 2, 3, 5, 0);
        add(0, 0, 'h00, 0, 0, 0, 2, 3, 0, 0);
        // reload coinciding with expiry wins
        add(0, 1, 'h05, 0, 0, 0, 2, 3, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 'h00, 0, 0, 0, 2, 3, 4, 0);
        add(0, 1, 'h09, 0, 0, 0, 2, 3, 4, 0);
        add(0, 0, 'h00, 0, 0, 0, 2, 3, 2, 0);
        add(0, 0, 'h00, 0, 3, 0, 2, 3, 0, 0);
        add(0, 0, 'h00, 3, 0, 1, 2, 3, 6, 0);
        add(0, 0, 'h00, 0, 0, 0, 2, 3, 2, 0);
        // remaining key codes
        add(0, 1, 'h00, 0, 0, 0, 2, 3, 2, 0);
        add(0, 1, 'h11, 0, 0, 0, 2, 3, 6, 0);
        add(0, 1, 'h17, 0, 0, 0, 2, 3, 7, 0);
        add(0, 1, 'h0C, 0, 0, 0, 2, 3, 8, 0);
        add(0, 0, 'h00, 0, 0, 0, 2, 3, 0, 0);
        // same-mode key, IDLE, back-to-back mode changes
        add(0, 1, 'h13, 0, 0, 0, 2, 3, 0, 0);
        add(0, 1, 'h10, 0, 0, 0, 0, 3, 0, 1);
        add(0, 0, 'h00, 1, 0, 1, 0, 3, 0, 0);
        add(0, 1, 'h13, 0, 0, 0, 2, 3, 0, 1);
        add(0, 1, 'h0F, 0, 0, 0, 1, 0, 0, 1);
        add(0, 1, 'h10, 0, 0, 0, 0, 3, 1, 1);
        add(0, 0, 'h00, 0, 0, 0, 0, 3, 0, 0);

        foreach (tbl[i]) apply(tbl[i]);

        // reset asserted mid-hold together with a mode key
        apply(mk(0, 1, 'h13, 0, 0, 0, 2, 3, 0, 1));
        apply(mk(0, 1, 'h02, 0, 0, 0, 2, 3, 0, 0));
        apply(mk(0, 0, 'h00, 0, 0, 0, 2, 3, 5, 0));
        apply(mk(1, 1, 'h0F, 0, 0, 1, 0, 3, 0, 1));
        apply(mk(0, 0, 'h00, 0, 0, 0, 0, 3, 0, 0));
        apply(mk(0, 1, 'h13, 0, 0, 0, 2, 3, 0, 1));
        apply(mk(0, 0, 'h00, 0, 0, 0, 2, 3, 0, 0));

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
